// File: rtl/i2c_bus_frontend_if.sv
// -----------------------------------------------------------------------------
// i2c_bus_frontend_if
// Bundles the raw I2C pin inputs and the conditioned outputs of
// i2c_bus_frontend.
//   slave  : view taken by i2c_bus_frontend (pins in, conditioned outputs out)
//   master : view taken by whoever drives the pins and consumes the outputs
// Signals:
//   scl_in, sda_in           raw master SCL/SDA
//   scl_f, sda_f             filtered levels
//   scl_rise, scl_fall       filtered SCL edge strobes
//   start_det, rstart_det    START while idle / while busy strobes
//   stop_det                 STOP strobe
//   bus_busy                 high from START to STOP
//   bit_cnt                  data bits captured in current byte (0..8)
//   byte_valid, byte_data    framed byte strobe and value
//   ack_valid, ack_bit       9th-bit strobe and level (0 = ACK)
//   timeout                  SCL-stuck-low strobe
// -----------------------------------------------------------------------------
interface i2c_bus_frontend_if;
    logic       scl_in;
    logic       sda_in;
    logic       scl_f;
    logic       sda_f;
    logic       scl_rise;
    logic       scl_fall;
    logic       start_det;
    logic       rstart_det;
    logic       stop_det;
    logic       bus_busy;
    logic [3:0] bit_cnt;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       ack_valid;
    logic       ack_bit;
    logic       timeout;

    modport slave (
        input  scl_in, sda_in,
        output scl_f, sda_f, scl_rise, scl_fall, start_det, rstart_det,
               stop_det, bus_busy, bit_cnt, byte_valid, byte_data,
               ack_valid, ack_bit, timeout
    );

    modport master (
        output scl_in, sda_in,
        input  scl_f, sda_f, scl_rise, scl_fall, start_det, rstart_det,
               stop_det, bus_busy, bit_cnt, byte_valid, byte_data,
               ack_valid, ack_bit, timeout
    );
endinterface

// File: rtl/i2c_bus_frontend.sv
// -----------------------------------------------------------------------------
// i2c_bus_frontend
// Conditions the raw master SCL/SDA pins for the address-translation path:
// synchronises and glitch-filters both lines, detects START / repeated START /
// STOP, and frames the serial stream into bytes plus ACK bits. The block only
// observes the bus, it never drives it.
//
// Ports:
//   clk   system clock
//   rst   asynchronous, active-high reset
//   bus   i2c_bus_frontend_if.slave (raw pins in, conditioned outputs out)
//
// Parameters:
//   SYNC_STAGES     synchroniser depth per line (>= 2)
//   FILTER_LEN      clocks a new level must persist before being accepted (1..15)
//   TIMEOUT_CYCLES  SCL-low timeout threshold (only with I2C_TIMEOUT_EN)
//
// Optional feature macro: I2C_TIMEOUT_EN
//   defined   : SCL held low while busy for TIMEOUT_CYCLES clocks pulses
//               timeout and forces the framer back to idle (no stop_det)
//   undefined : no timeout counter, timeout is constant 0
// -----------------------------------------------------------------------------
module i2c_bus_frontend #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input logic                clk,
    input logic                rst,
    i2c_bus_frontend_if.slave  bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    localparam logic [3:0] FLEN_M1 = 4'(FILTER_LEN - 1);

    // Reject parameter sets the filter/synchroniser cannot implement
    if (SYNC_STAGES < 2 || FILTER_LEN < 1 || FILTER_LEN > 15 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("i2c_bus_frontend: illegal parameter value");
    end

    // ---------------------------------------------------------------- state
    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic [3:0] scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;
    logic       scl_f_q, scl_f_d, sda_f_q, sda_f_d;
    logic       scl_dly_q, sda_dly_q;

    logic [1:0] state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] byte_data_q, byte_data_d;
    logic       ack_bit_q, ack_bit_d;
    logic       busy_q, busy_d;

    logic       scl_rise_q, scl_fall_q, start_det_q, rstart_det_q, stop_det_q;
    logic       byte_valid_q, byte_valid_d, ack_valid_q, ack_valid_d, timeout_q;

    logic       scl_rise_s, scl_fall_s, scl_high_s, start_s, stop_s, timeout_s;

    // Synchroniser chains, reset to the idle-high bus level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], bus.scl_in};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], bus.sda_in};
        end
    end

    // Persistence filters: a differing level must be seen FILTER_LEN clocks in a row
    always_comb begin
        scl_f_d   = scl_f_q;
        scl_cnt_d = 4'd0;
        if (scl_sync_q[SYNC_STAGES-1] != scl_f_q) begin
            if (scl_cnt_q == FLEN_M1) begin
                scl_f_d   = scl_sync_q[SYNC_STAGES-1];
                scl_cnt_d = 4'd0;
            end else begin
                scl_cnt_d = scl_cnt_q + 4'd1;
            end
        end else begin
            scl_cnt_d = 4'd0;
        end

        sda_f_d   = sda_f_q;
        sda_cnt_d = 4'd0;
        if (sda_sync_q[SYNC_STAGES-1] != sda_f_q) begin
            if (sda_cnt_q == FLEN_M1) begin
                sda_f_d   = sda_sync_q[SYNC_STAGES-1];
                sda_cnt_d = 4'd0;
            end else begin
                sda_cnt_d = sda_cnt_q + 4'd1;
            end
        end else begin
            sda_cnt_d = 4'd0;
        end
    end

    // Filtered levels, their one-cycle delayed copies and filter counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_f_q   <= 1'b1;
            sda_f_q   <= 1'b1;
            scl_dly_q <= 1'b1;
            sda_dly_q <= 1'b1;
            scl_cnt_q <= 4'd0;
            sda_cnt_q <= 4'd0;
        end else begin
            scl_f_q   <= scl_f_d;
            sda_f_q   <= sda_f_d;
            scl_dly_q <= scl_f_q;
            sda_dly_q <= sda_f_q;
            scl_cnt_q <= scl_cnt_d;
            sda_cnt_q <= sda_cnt_d;
        end
    end

    // Conditions need SCL stable high across the SDA edge; a simultaneous
    // SCL edge therefore never qualifies as START/STOP.
    assign scl_rise_s = scl_f_q & ~scl_dly_q;
    assign scl_fall_s = ~scl_f_q & scl_dly_q;
    assign scl_high_s = scl_f_q & scl_dly_q;
    assign start_s    = scl_high_s & ~sda_f_q & sda_dly_q;
    assign stop_s     = scl_high_s & sda_f_q & ~sda_dly_q;

`ifdef I2C_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    // SCL-low watchdog: counts only while a transfer is in progress
    always_comb begin
        to_cnt_d  = '0;
        timeout_s = 1'b0;
        if (busy_q && !scl_f_q) begin
            if (to_cnt_q == TO_LAST) begin
                timeout_s = 1'b1;
                to_cnt_d  = '0;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end else begin
            to_cnt_d = '0;
        end
    end

    // Watchdog counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Framing FSM; bus-level events take priority over bit clocking
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        byte_data_d  = byte_data_q;
        ack_bit_d    = ack_bit_q;
        busy_d       = busy_q;
        byte_valid_d = 1'b0;
        ack_valid_d  = 1'b0;

        if (timeout_s) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 4'd0;
            busy_d    = 1'b0;
        end else if (stop_s) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 4'd0;
            busy_d    = 1'b0;
        end else if (start_s) begin
            state_d   = ST_DATA;
            bit_cnt_d = 4'd0;
            busy_d    = 1'b1;
        end else if (scl_rise_s) begin
            case (state_q)
                ST_DATA: begin
                    shift_d = {shift_q[6:0], sda_f_q};
                    if (bit_cnt_q == 4'd7) begin
                        byte_data_d  = {shift_q[6:0], sda_f_q};
                        byte_valid_d = 1'b1;
                        bit_cnt_d    = 4'd8;
                        state_d      = ST_ACK;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
                ST_ACK: begin
                    ack_bit_d   = sda_f_q;
                    ack_valid_d = 1'b1;
                    bit_cnt_d   = 4'd0;
                    state_d     = ST_DATA;
                end
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = 4'd0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // FSM, framing data and registered one-cycle strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= 4'd0;
            shift_q      <= 8'd0;
            byte_data_q  <= 8'd0;
            ack_bit_q    <= 1'b0;
            busy_q       <= 1'b0;
            scl_rise_q   <= 1'b0;
            scl_fall_q   <= 1'b0;
            start_det_q  <= 1'b0;
            rstart_det_q <= 1'b0;
            stop_det_q   <= 1'b0;
            byte_valid_q <= 1'b0;
            ack_valid_q  <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            byte_data_q  <= byte_data_d;
            ack_bit_q    <= ack_bit_d;
            busy_q       <= busy_d;
            scl_rise_q   <= scl_rise_s;
            scl_fall_q   <= scl_fall_s;
            start_det_q  <= start_s & ~busy_q;
            rstart_det_q <= start_s & busy_q;
            stop_det_q   <= stop_s;
            byte_valid_q <= byte_valid_d;
            ack_valid_q  <= ack_valid_d;
            timeout_q    <= timeout_s;
        end
    end

    assign bus.scl_f      = scl_f_q;
    assign bus.sda_f      = sda_f_q;
    assign bus.scl_rise   = scl_rise_q;
    assign bus.scl_fall   = scl_fall_q;
    assign bus.start_det  = start_det_q;
    assign bus.rstart_det = rstart_det_q;
    assign bus.stop_det   = stop_det_q;
    assign bus.bus_busy   = busy_q;
    assign bus.bit_cnt    = bit_cnt_q;
    assign bus.byte_valid = byte_valid_q;
    assign bus.byte_data  = byte_data_q;
    assign bus.ack_valid  = ack_valid_q;
    assign bus.ack_bit    = ack_bit_q;
    assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_i2c_bus_frontend.sv
// -----------------------------------------------------------------------------
// tb_i2c_bus_frontend
// Directed bench for i2c_bus_frontend (SYNC_STAGES=2, FILTER_LEN=4,
// TIMEOUT_CYCLES=100). Stimulus pushes the expected event stream into a
// queue; a monitor on the falling clock edge pops and compares every strobe.
// -----------------------------------------------------------------------------
module tb_i2c_bus_frontend;

    localparam int HOLD = 10;

    localparam logic [7:0] EV_START  = 8'd1;
    localparam logic [7:0] EV_RSTART = 8'd2;
    localparam logic [7:0] EV_STOP   = 8'd3;
    localparam logic [7:0] EV_BYTE   = 8'd4;
    localparam logic [7:0] EV_ACK    = 8'd5;
    localparam logic [7:0] EV_TMO    = 8'd6;

    typedef struct packed {
        logic [7:0] kind;
        logic [7:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;
    ev_t  exp_q[$];

    always #5 clk = ~clk;

    i2c_bus_frontend_if bus ();

    i2c_bus_frontend #(
        .SYNC_STAGES    (2),
        .FILTER_LEN     (4),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input logic [7:0] kind, input logic [7:0] data);
        exp_q.push_back('{kind: kind, data: data});
    endtask

    task automatic observe(input logic [7:0] kind, input logic [7:0] data);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_event: got kind %0d data %0h, required none", kind, data);
        end else begin
            e = exp_q.pop_front();
            check("event", {16'd0, kind, data}, {16'd0, e.kind, e.data});
        end
    endtask

    // Monitor: every strobe must match the head of the expected queue
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.start_det)  observe(EV_START, 8'd0);
            if (bus.rstart_det) observe(EV_RSTART, 8'd0);
            if (bus.stop_det)   observe(EV_STOP, 8'd0);
            if (bus.byte_valid) observe(EV_BYTE, bus.byte_data);
            if (bus.ack_valid)  observe(EV_ACK, {7'd0, bus.ack_bit});
            if (bus.timeout)    observe(EV_TMO, 8'd0);
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        bus.sda_in = b;
        wait_cyc(HOLD);
        bus.scl_in = 1'b1;
        wait_cyc(HOLD);
        bus.scl_in = 1'b0;
        wait_cyc(HOLD);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic do_start();
        bus.sda_in = 1'b1;
        wait_cyc(HOLD);
        bus.scl_in = 1'b1;
        wait_cyc(HOLD);
        bus.sda_in = 1'b0;
        wait_cyc(HOLD);
        bus.scl_in = 1'b0;
        wait_cyc(HOLD);
    endtask

    task automatic do_stop();
        bus.sda_in = 1'b0;
        wait_cyc(HOLD);
        bus.scl_in = 1'b1;
        wait_cyc(HOLD);
        bus.sda_in = 1'b1;
        wait_cyc(HOLD);
    endtask

    // Watchdog so the bench always terminates
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       bad;
        logic [7:0] hist;
        logic [3:0] cnt_before;

        bus.scl_in = 1'b1;
        bus.sda_in = 1'b1;
        rst = 1'b1;
        wait_cyc(3);
        rst = 1'b0;

        // Reset / idle
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.scl_f !== 1'b1 || bus.sda_f !== 1'b1 || bus.bus_busy !== 1'b0 ||
                bus.scl_rise || bus.scl_fall || bus.start_det || bus.rstart_det ||
                bus.stop_det || bus.byte_valid || bus.ack_valid || bus.timeout)
                bad = 1'b1;
        end
        check("reset_idle_levels", 32'(bad), 32'd0);
        check("reset_bit_cnt", 32'(bus.bit_cnt), 32'd0);
        check("reset_byte_data", 32'(bus.byte_data), 32'd0);
        check("reset_ack_bit", 32'(bus.ack_bit), 32'd0);

        // 3-cycle SDA glitch is filtered out
        bad = 1'b0;
        bus.sda_in = 1'b0;
        wait_cyc(3);
        bus.sda_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.sda_f !== 1'b1) bad = 1'b1;
        end
        check("glitch3_sda_f", 32'(bad), 32'd0);

        // 4-cycle SDA low: accepted, START 7 clocks after raw edge, then STOP
        expect_ev(EV_START, 8'd0);
        expect_ev(EV_STOP, 8'd0);
        hist = 8'd0;
        bus.sda_in = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 4) bus.sda_in = 1'b1;
            hist[k-1] = bus.start_det;
            if (k == 7) check("glitch4_bus_busy", 32'(bus.bus_busy), 32'd1);
        end
        check("start_latency", 32'(hist), 32'h40);
        wait_cyc(20);
        check("glitch4_busy_after_stop", 32'(bus.bus_busy), 32'd0);

        // START, 0x92, ACK, STOP
        expect_ev(EV_START, 8'd0);
        do_start();
        check("t1_busy", 32'(bus.bus_busy), 32'd1);
        expect_ev(EV_BYTE, 8'h92);
        send_byte(8'h92);
        check("t1_bit_cnt_8", 32'(bus.bit_cnt), 32'd8);
        expect_ev(EV_ACK, 8'd0);
        send_bit(1'b0);
        expect_ev(EV_STOP, 8'd0);
        do_stop();
        check("t1_busy_end", 32'(bus.bus_busy), 32'd0);
        check("t1_bit_cnt_end", 32'(bus.bit_cnt), 32'd0);

        // START, 0x90, ACK, partial 101, repeated START, 0x91, NACK, STOP
        expect_ev(EV_START, 8'd0);
        do_start();
        expect_ev(EV_BYTE, 8'h90);
        send_byte(8'h90);
        expect_ev(EV_ACK, 8'd0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        expect_ev(EV_RSTART, 8'd0);
        do_start();
        check("t2_bit_cnt_after_rstart", 32'(bus.bit_cnt), 32'd0);
        expect_ev(EV_BYTE, 8'h91);
        send_byte(8'h91);
        expect_ev(EV_ACK, 8'd1);
        send_bit(1'b1);
        expect_ev(EV_STOP, 8'd0);
        do_stop();
        check("t2_ack_bit", 32'(bus.ack_bit), 32'd1);
        check("t2_byte_data", 32'(bus.byte_data), 32'h91);

        // START, 5 bits, STOP: partial byte discarded
        expect_ev(EV_START, 8'd0);
        do_start();
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        check("t3_bit_cnt_5", 32'(bus.bit_cnt), 32'd5);
        expect_ev(EV_STOP, 8'd0);
        do_stop();
        check("t3_byte_data_kept", 32'(bus.byte_data), 32'h91);
        check("t3_bit_cnt_end", 32'(bus.bit_cnt), 32'd0);

        // SCL pulse with no START: ignored while idle
        bus.scl_in = 1'b0;
        wait_cyc(HOLD);
        bus.scl_in = 1'b1;
        wait_cyc(HOLD);
        check("idle_rise_bit_cnt", 32'(bus.bit_cnt), 32'd0);

        // Asynchronous reset mid-transfer
        expect_ev(EV_START, 8'd0);
        do_start();
        send_bit(1'b1);
        send_bit(1'b0);
        cnt_before = bus.bit_cnt;
        check("mid_bit_cnt_before_reset", 32'(cnt_before), 32'd2);
        #3;
        rst = 1'b1;
        #1;
        check("async_reset_busy", 32'(bus.bus_busy), 32'd0);
        check("async_reset_bit_cnt", 32'(bus.bit_cnt), 32'd0);
        check("async_reset_byte_data", 32'(bus.byte_data), 32'd0);
        bus.sda_in = 1'b1;
        bus.scl_in = 1'b1;
        wait_cyc(5);
        rst = 1'b0;
        wait_cyc(HOLD);

        // SCL held low after START
        expect_ev(EV_START, 8'd0);
        do_start();
`ifdef I2C_TIMEOUT_EN
        expect_ev(EV_TMO, 8'd0);
        wait_cyc(150);
        check("timeout_busy_cleared", 32'(bus.bus_busy), 32'd0);
        check("timeout_bit_cnt", 32'(bus.bit_cnt), 32'd0);
        bus.sda_in = 1'b1;
        wait_cyc(HOLD);
        bus.scl_in = 1'b1;
        wait_cyc(HOLD);
`else
        bad = 1'b0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (bus.timeout !== 1'b0) bad = 1'b1;
        end
        check("no_timeout", 32'(bad), 32'd0);
        check("no_timeout_busy", 32'(bus.bus_busy), 32'd1);
        expect_ev(EV_STOP, 8'd0);
        do_stop();
`endif

        wait_cyc(20);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/i2c_bus_frontend.md
Name: i2c_bus_frontend

Overview:
Upstream conditioning stage for the I2C address-translation path. It synchronises and glitch-filters the raw master SCL/SDA pins, detects START, repeated START and STOP conditions, and frames the serial stream into bytes with ACK bits. Downstream translation logic consumes clean levels, one-cycle event strobes and framed bytes instead of sampling raw pins itself.

Parameters:
SYNC_STAGES, 2, synchroniser depth per line (min 2)
FILTER_LEN, 4, consecutive clocks a new level must persist before the filtered line follows (1..15)
TIMEOUT_CYCLES, 65535, SCL-low timeout threshold; used only with I2C_TIMEOUT_EN

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
scl_in  in  1  raw master SCL
sda_in  in  1  raw master SDA
scl_f  out  1  filtered SCL
sda_f  out  1  filtered SDA
scl_rise  out  1  one-cycle strobe, filtered SCL rising
scl_fall  out  1  one-cycle strobe, filtered SCL falling
start_det  out  1  one-cycle strobe, START while bus idle
rstart_det  out  1  one-cycle strobe, START while bus busy
stop_det  out  1  one-cycle strobe, STOP
bus_busy  out  1  high from START to STOP
bit_cnt  out  4  data bits captured in current byte (0..8)
byte_valid  out  1  one-cycle strobe, byte_data updated
byte_data  out  8  last complete byte, MSB first on wire
ack_valid  out  1  one-cycle strobe, ack_bit updated
ack_bit  out  1  9th-bit SDA level (0 = ACK)
timeout  out  1  one-cycle strobe, SCL stuck low (0 without macro)

Behaviour:
- Reset (async, immediate, including mid-transfer): sync flops, scl_f, sda_f and their delayed copies = 1. All strobes, bus_busy, bit_cnt, byte_data, ack_bit and filter counters = 0. FSM = IDLE.
- Synchroniser: SYNC_STAGES flops per line.
- Filter, per line: counter increments while last sync stage != filtered value and clears when equal. When it reaches FILTER_LEN, the filtered value takes the sync value and the counter clears.
  - Pulses shorter than FILTER_LEN clocks are invisible.
  - Raw change to filtered change = SYNC_STAGES + FILTER_LEN clocks.
- Edge/condition detection uses filtered values and their 1-cycle delayed copies. All strobes are registered, asserting in the cycle after the filtered transition, for exactly 1 cycle.
  - START: SDA 1->0 while scl_f and its delayed copy are both 1. Gives start_det if bus_busy=0, else rstart_det. Sets bus_busy.
  - STOP: SDA 1->0 reversed (0->1) under the same SCL condition. Gives stop_det and clears bus_busy. A STOP while idle still strobes stop_det.
  - If the SDA and SCL transitions land in the same cycle, no START/STOP is detected; the SCL edge is processed normally.
- Framing FSM with states IDLE, DATA, ACK:
  - IDLE: scl_rise ignored. START/rstart -> DATA with bit_cnt=0.
  - DATA: each scl_rise shifts sda_f into the shift register LSB end and increments bit_cnt. On the 8th bit, byte_data loads and byte_valid pulses in the same cycle as the transfer to ACK; bit_cnt reads 8.
  - ACK: next scl_rise latches ack_bit=sda_f, pulses ack_valid, sets bit_cnt=0 -> DATA.
  - STOP in any state -> IDLE, bit_cnt=0. A partial byte is discarded: no byte_valid, byte_data retained.
  - Repeated START in DATA/ACK -> DATA, bit_cnt=0, partial byte discarded.
- byte_data and ack_bit hold until the next update. The block never drives the bus.

Optional Feature:
I2C_TIMEOUT_EN
- Defined: a counter runs while bus_busy=1 and scl_f=0, and clears on any scl_f=1. On reaching TIMEOUT_CYCLES: timeout pulses 1 cycle, FSM -> IDLE, bus_busy=0, bit_cnt=0, no stop_det.
- Undefined: no counter is built, timeout is tied 0, and TIMEOUT_CYCLES is ignored.

Test Plan:
- Reset with both pins 1, release -> scl_f=sda_f=1, all strobes 0, bus_busy=0 for 50 cycles.
- SDA 3-cycle low glitch with SCL=1 (FILTER_LEN=4) -> sda_f stays 1, no start_det. Same with a 4-cycle low -> sda_f falls, start_det one pulse exactly SYNC_STAGES+FILTER_LEN+1 = 7 clocks after the raw edge, bus_busy=1.
- START, byte 0x92 (address 49H, write), ACK=0, STOP -> byte_valid once with byte_data=0x92, ack_valid with ack_bit=0, stop_det, bus_busy=0, bit_cnt=0.
- START, 0x90, ACK, 3 bits of 101, repeated START, 0x91, NACK -> rstart_det once, byte_valid exactly twice (0x90, 0x91), final ack_bit=1, no byte_valid for the partial byte.
- START, 5 bits, STOP -> no byte_valid, byte_data unchanged, FSM IDLE. Then an scl_rise with no START -> bit_cnt stays 0.
- With I2C_TIMEOUT_EN and TIMEOUT_CYCLES=100: START, hold SCL low 100 filtered cycles -> timeout pulse, bus_busy=0. Without the macro -> timeout stays 0 and bus_busy stays 1.
